// File: rtl/batch_sample_seq.sv
// ---------------------------------------------------------------------------
// batch_sample_seq
//
// Sample-buffer sequencer for the batch filter datapath. Incoming samples are
// packed DSR1 at a time into one RAM word. Each word goes into a circular
// buffer of n_seg segments of seg_len words each. For every write, n_rd read
// streams are generated. Each read stream lags the write segment by a fixed
// number of segments and walks its segment either ascending or descending.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   in           input sample (N bits)
//   in_valid     sample qualifier
//   wr_en        RAM write strobe (one cycle per packed word)
//   wr_addr      RAM write address
//   wr_data      packed word, slot 0 (oldest sample) in the LSBs
//   rd_addr      read addresses, port p in bits [AW*p +: AW]
//   rd_en        read strobe per port
//   batch_start  pulse coincident with the last word of a segment
//   seg_idx      segment currently being written
// ---------------------------------------------------------------------------
module batch_sample_seq #(
    parameter int                  N         = 4,
    parameter int                  DSR1      = 2,
    parameter int                  DSR2      = 6,
    parameter int                  depth     = 220,
    parameter int                  n_seg     = 4,
    parameter int                  n_rd      = 3,
    parameter logic [8*n_rd-1:0]   RD_OFFSET = {8'd2, 8'd2, 8'd1},
    parameter logic [n_rd-1:0]     RD_DIR    = 3'b011,
    localparam int SEG_LEN = ((depth + DSR1*DSR2 - 1) / (DSR1*DSR2)) * DSR2,
    localparam int AW      = $clog2(n_seg*SEG_LEN),
    localparam int SGW     = $clog2(n_seg)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in,
    input  logic                 in_valid,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [N*DSR1-1:0]    wr_data,
    output logic [n_rd*AW-1:0]   rd_addr,
    output logic [n_rd-1:0]      rd_en,
    output logic                 batch_start,
    output logic [SGW-1:0]       seg_idx
);

    localparam int SW = (DSR1 > 1) ? $clog2(DSR1) : 1;
    localparam int WW = (SEG_LEN > 1) ? $clog2(SEG_LEN) : 1;

    // Elaboration-time parameter checks
    if (DSR1 < 1) begin : g_bad_dsr1
        $error("batch_sample_seq: DSR1 must be >= 1");
    end
    if (n_seg < 2 || (n_seg & (n_seg - 1)) != 0) begin : g_bad_nseg
        $error("batch_sample_seq: n_seg must be a power of two >= 2");
    end
    for (genvar gp = 0; gp < n_rd; gp++) begin : g_chk_off
        if (RD_OFFSET[8*gp +: 8] == 8'd0 || int'(RD_OFFSET[8*gp +: 8]) >= n_seg) begin : g_bad_off
            $error("batch_sample_seq: RD_OFFSET out of range 1..n_seg-1");
        end
    end

    logic [SW-1:0]        slot_q, slot_d;
    logic [N*DSR1-1:0]    pack_q, pack_d;
    logic [WW-1:0]        w_q, w_d;
    logic [SGW-1:0]       seg_q, seg_d;
    logic [SGW-1:0]       c_q, c_d;
    logic                 wr_en_q, wr_en_d;
    logic [AW-1:0]        wr_addr_q, wr_addr_d;
    logic [N*DSR1-1:0]    wr_data_q, wr_data_d;
    logic [n_rd*AW-1:0]   rd_addr_q, rd_addr_d;
    logic [n_rd-1:0]      rd_en_q, rd_en_d;
    logic                 batch_start_q, batch_start_d;
    logic [SGW-1:0]       seg_idx_q, seg_idx_d;

    logic [N*DSR1-1:0]    word_full;
    logic [SGW-1:0]       rseg;
    logic [AW-1:0]        roff;
    int                   o;

    always_comb begin
        slot_d        = slot_q;
        pack_d        = pack_q;
        w_d           = w_q;
        seg_d         = seg_q;
        c_d           = c_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        rd_addr_d     = rd_addr_q;
        rd_en_d       = '0;
        batch_start_d = 1'b0;
        // Lags seg by one cycle so the new segment shows after the wrap write
        seg_idx_d     = seg_q;
        rseg          = '0;
        roff          = '0;
        o             = 0;

        word_full = pack_q;
        word_full[N*int'(slot_q) +: N] = in;

        if (in_valid) begin
            pack_d = word_full;
            if (slot_q == SW'(DSR1 - 1)) begin
                slot_d    = '0;
                wr_en_d   = 1'b1;
                wr_data_d = word_full;
                wr_addr_d = AW'(seg_q) * AW'(SEG_LEN) + AW'(w_q);

                // Read streams use the same pre-increment seg/w/c as the write
                for (int p = 0; p < n_rd; p++) begin
                    o = int'(RD_OFFSET[8*p +: 8]);
                    if (int'(c_q) >= o) begin
                        rseg = seg_q - SGW'(o);
                        roff = RD_DIR[p] ? (AW'(SEG_LEN - 1) - AW'(w_q)) : AW'(w_q);
                        rd_en_d[p] = 1'b1;
                        rd_addr_d[AW*p +: AW] = AW'(rseg) * AW'(SEG_LEN) + roff;
                    end
                end

                if (w_q == WW'(SEG_LEN - 1)) begin
                    w_d           = '0;
                    seg_d         = seg_q + 1'b1;
                    batch_start_d = 1'b1;
                    if (c_q != SGW'(n_seg - 1)) begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    w_d = w_q + 1'b1;
                end
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q        <= '0;
            pack_q        <= '0;
            w_q           <= '0;
            seg_q         <= '0;
            c_q           <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_addr_q     <= '0;
            rd_en_q       <= '0;
            batch_start_q <= 1'b0;
            seg_idx_q     <= '0;
        end else begin
            slot_q        <= slot_d;
            pack_q        <= pack_d;
            w_q           <= w_d;
            seg_q         <= seg_d;
            c_q           <= c_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rd_addr_q     <= rd_addr_d;
            rd_en_q       <= rd_en_d;
            batch_start_q <= batch_start_d;
            seg_idx_q     <= seg_idx_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_addr     = rd_addr_q;
    assign rd_en       = rd_en_q;
    assign batch_start = batch_start_q;
    assign seg_idx     = seg_idx_q;

`ifndef SYNTHESIS
    logic wr_en_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_prev_q <= 1'b0;
        end else begin
            wr_en_prev_q <= wr_en_q;
            if (DSR1 > 1) begin
                assert (!(wr_en_q && wr_en_prev_q))
                    else $error("batch_sample_seq: wr_en on consecutive cycles");
            end
            for (int p = 0; p < n_rd; p++) begin
                assert (!(wr_en_q && rd_en_q[p] && rd_addr_q[AW*p +: AW] == wr_addr_q))
                    else $error("batch_sample_seq: read port %0d collides with write", p);
            end
        end
    end
`endif

endmodule
